// File: rtl/decode_stage.sv
// RV64I decode stage: register file, scoreboard, hazard detection and the
// AGEX pipeline latch. Optional macro DECODE_WB_BYPASS_EN forwards same-cycle
// writeback data and busy-bit clears into decode.
module decode_stage #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            DE_V,
  input  logic [31:0]     DE_IR,
  input  logic [XLEN-1:0] DE_NPC,
  input  logic            mem_stall,
  input  logic            MEM_FLUSH,
  input  logic            WB_V,
  input  logic            WB_LD_REG,
  input  logic [4:0]      WB_DRID,
  input  logic [XLEN-1:0] WB_DATA,
  output logic            AGEX_V,
  output logic [XLEN-1:0] AGEX_NPC,
  output logic [31:0]     AGEX_IR,
  output logic [XLEN-1:0] AGEX_SR1,
  output logic [XLEN-1:0] AGEX_SR2,
  output logic [XLEN-1:0] AGEX_IMM,
  output logic [4:0]      AGEX_DRID,
  output logic            AGEX_LD_REG,
  output logic            AGEX_II,
  output logic            dep_stall,
  output logic            v_de_br_stall
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OPW    = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic            v;
    logic [XLEN-1:0] npc;
    logic [31:0]     ir;
    logic [XLEN-1:0] sr1;
    logic [XLEN-1:0] sr2;
    logic [XLEN-1:0] imm;
    logic [4:0]      drid;
    logic            ld_reg;
    logic            ii;
  } agex_t;

  agex_t            agex_q, agex_d;
  logic [XLEN-1:0]  rf_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d, clr_mask, set_mask, busy_chk;

  logic [6:0]      opc;
  logic [4:0]      rs1, rs2, rd;
  logic            legal, use1, use2, rd_wr, ctrl, ecall, ld_reg, sb_set, wb_we;
  logic [XLEN-1:0] imm, rd1, rd2;

  assign opc   = DE_IR[6:0];
  assign rs1   = DE_IR[19:15];
  assign rs2   = DE_IR[24:20];
  assign rd    = DE_IR[11:7];
  assign wb_we = WB_V && WB_LD_REG && (WB_DRID != 5'd0);
  assign ecall = (opc == OPC_SYSTEM) && (DE_IR[31:7] == 25'd0);

  // Opcode classification: legality, source usage, immediate format
  always_comb begin
    legal = 1'b1; use1 = 1'b0; use2 = 1'b0; ctrl = 1'b0; imm = '0;
    unique case (opc)
      OPC_LOAD, OPC_OPIMM, OPC_OPIMMW: begin
        use1 = 1'b1;
        imm  = {{(XLEN-12){DE_IR[31]}}, DE_IR[31:20]};
      end
      OPC_JALR: begin
        use1 = 1'b1; ctrl = 1'b1;
        imm  = {{(XLEN-12){DE_IR[31]}}, DE_IR[31:20]};
      end
      OPC_SYSTEM: begin
        ctrl = 1'b1;
        imm  = {{(XLEN-12){DE_IR[31]}}, DE_IR[31:20]};
      end
      OPC_STORE: begin
        use1 = 1'b1; use2 = 1'b1;
        imm  = {{(XLEN-12){DE_IR[31]}}, DE_IR[31:25], DE_IR[11:7]};
      end
      OPC_BRANCH: begin
        use1 = 1'b1; use2 = 1'b1; ctrl = 1'b1;
        imm  = {{(XLEN-13){DE_IR[31]}}, DE_IR[31], DE_IR[7], DE_IR[30:25], DE_IR[11:8], 1'b0};
      end
      OPC_JAL: begin
        ctrl = 1'b1;
        imm  = {{(XLEN-21){DE_IR[31]}}, DE_IR[31], DE_IR[19:12], DE_IR[20], DE_IR[30:21], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: imm = {{(XLEN-32){DE_IR[31]}}, DE_IR[31:12], 12'd0};
      OPC_OP, OPC_OPW: begin
        use1 = 1'b1; use2 = 1'b1;
      end
      OPC_FENCE: ;
      default: legal = 1'b0;
    endcase
    if (DE_IR[1:0] != 2'b11) legal = 1'b0;
  end

  assign rd_wr  = legal && (opc != OPC_STORE) && (opc != OPC_BRANCH) && !ecall;
  assign ld_reg = rd_wr && (rd != 5'd0);

  // Writeback clear mask; with bypass the same-cycle clear is visible to the hazard check
  always_comb begin
    clr_mask = '0;
    for (int r = 1; r < NREGS; r++) clr_mask[r] = wb_we && (WB_DRID == 5'(r));
`ifdef DECODE_WB_BYPASS_EN
    busy_chk = busy_q & ~clr_mask;
`else
    busy_chk = busy_q;
`endif
  end

  assign dep_stall = DE_V && ((use1 && busy_chk[rs1]) || (use2 && busy_chk[rs2]) ||
                              (rd_wr && busy_chk[rd]));
  assign v_de_br_stall = DE_V && ctrl;

  // Register file read ports; x0 reads as zero
  always_comb begin
    rd1 = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    rd2 = (rs2 == 5'd0) ? '0 : rf_q[rs2];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_we && (WB_DRID == rs1)) rd1 = WB_DATA;
    if (wb_we && (WB_DRID == rs2)) rd2 = WB_DATA;
`endif
  end

  // AGEX latch next state: stall holds, flush kills valid, else latch decode
  always_comb begin
    agex_d = agex_q;
    sb_set = 1'b0;
    if (!mem_stall) begin
      if (MEM_FLUSH) begin
        agex_d.v = 1'b0;
      end else begin
        agex_d.v      = DE_V && !dep_stall;
        agex_d.npc    = DE_NPC;
        agex_d.ir     = DE_IR;
        agex_d.sr1    = rd1;
        agex_d.sr2    = rd2;
        agex_d.imm    = imm;
        agex_d.drid   = rd;
        agex_d.ld_reg = ld_reg;
        agex_d.ii     = !legal;
        sb_set        = agex_d.v && ld_reg;
      end
    end
  end

  // Scoreboard next state: set wins over a same-register clear, x0 never busy
  always_comb begin
    set_mask = '0;
    for (int r = 1; r < NREGS; r++) set_mask[r] = sb_set && (rd == 5'(r));
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  // Pipeline latch and scoreboard registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      agex_q <= '0;
      busy_q <= '0;
    end else begin
      agex_q <= agex_d;
      busy_q <= busy_d;
    end
  end

  // Register file write port
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) rf_q[r] <= '0;
    end else if (wb_we) begin
      rf_q[WB_DRID] <= WB_DATA;
    end
  end

  assign AGEX_V      = agex_q.v;
  assign AGEX_NPC    = agex_q.npc;
  assign AGEX_IR     = agex_q.ir;
  assign AGEX_SR1    = agex_q.sr1;
  assign AGEX_SR2    = agex_q.sr2;
  assign AGEX_IMM    = agex_q.imm;
  assign AGEX_DRID   = agex_q.drid;
  assign AGEX_LD_REG = agex_q.ld_reg;
  assign AGEX_II     = agex_q.ii;

endmodule
